// File: rtl/integral_image_builder.sv
// Integral image builder: accepts a raster-order window of grayscale pixels and
// builds its summed-area table, one accepted pixel per cycle.
module integral_image_builder #(
  parameter int unsigned IMG_W = 20,
  parameter int unsigned IMG_H = 20,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic             pixel_valid,
  input  logic [PIX_W-1:0] pixel_data,
  output logic             pixel_ready,
  output logic [ACC_W-1:0] integral_buffer [IMG_W*IMG_H],
  output logic             START,
  output logic             busy
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e           state_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  // Linear write index y*IMG_W+x, tracked alongside x/y to avoid a multiplier.
  logic [AW-1:0]    idx_q;
  logic [ACC_W-1:0] row_sum_q;

  logic             accept;
  logic             last_x;
  logic             last_pix;
  logic [ACC_W-1:0] pix_ext;
  logic [AW-1:0]    above_idx;
  logic [ACC_W-1:0] above;
  logic [ACC_W-1:0] new_row_sum;
  logic [ACC_W-1:0] new_val;

  // Acceptance decode and the value written for the current pixel.
  always_comb begin
    // A pixel coinciding with frame_start (abort) is dropped.
    accept      = pixel_ready && pixel_valid && !frame_start;
    last_x      = (x_q == XW'(IMG_W - 1));
    last_pix    = last_x && (y_q == YW'(IMG_H - 1));
    pix_ext     = ACC_W'(pixel_data);
    above_idx   = (y_q == '0) ? '0 : (idx_q - AW'(IMG_W));
    above       = (y_q == '0) ? '0 : integral_buffer[above_idx];
    new_row_sum = row_sum_q + pix_ext;
    new_val     = new_row_sum + above;
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      row_sum_q   <= '0;
      pixel_ready <= 1'b0;
      START       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (frame_start) begin
            state_q     <= StFill;
            x_q         <= '0;
            y_q         <= '0;
            idx_q       <= '0;
            row_sum_q   <= '0;
            pixel_ready <= 1'b1;
            START       <= 1'b0;
            busy        <= 1'b1;
          end
        end
        StFill: begin
          if (frame_start) begin
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            row_sum_q <= '0;
          end else if (accept) begin
            if (last_pix) begin
              state_q     <= StDone;
              x_q         <= '0;
              y_q         <= '0;
              idx_q       <= '0;
              row_sum_q   <= '0;
              pixel_ready <= 1'b0;
              START       <= 1'b1;
              busy        <= 1'b0;
            end else begin
              idx_q <= idx_q + AW'(1);
              if (last_x) begin
                x_q       <= '0;
                y_q       <= y_q + YW'(1);
                row_sum_q <= '0;
              end else begin
                x_q       <= x_q + XW'(1);
                row_sum_q <= new_row_sum;
              end
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          pixel_ready <= 1'b0;
          START       <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Buffer write on acceptance; contents are never cleared, only overwritten.
  always_ff @(posedge Clk) begin
    if (accept) begin
      integral_buffer[idx_q] <= new_val;
    end
  end

endmodule
